// File: rtl/game_round_sequencer.sv
// Round sequencer for one Znarly/Zood game.
// It takes one credit, collects the 4-shape master pattern and sends one
// grade request per guess to the external grader.
// It also counts completed rounds and decides win, lose and game-over.
module game_round_sequencer #(
    parameter int MAX_ROUNDS    = 8,
    parameter int GRADE_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        StartGame,
    input  logic [3:0]  numGames,
    output logic        useGame,
    input  logic [2:0]  LoadShape,
    input  logic [1:0]  ShapeLocation,
    input  logic        LoadShapeNow,
    output logic [11:0] masterPattern,
    input  logic [11:0] Guess,
    input  logic        GradeIt,
    output logic        gradeStart,
    output logic [11:0] gradeGuess,
    input  logic        gradeDone,
    input  logic [3:0]  gradeZnarly,
    input  logic [3:0]  gradeZood,
    output logic [3:0]  Znarly,
    output logic [3:0]  Zood,
    output logic [3:0]  RoundNumber,
    output logic        loadingShape,
    output logic        ongoingGame,
    output logic        GameWon,
    output logic        gameOver,
    output logic        gradeError
);

    localparam int TW = $clog2(GRADE_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        GUESS      = 3'd2,
        GRADE_WAIT = 3'd3,
        DONE       = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [3:0]    slot_mask;
    logic          grade_prev;
    logic [TW-1:0] timer;

    logic          start_ok;
    logic          grade_edge;
    logic          shape_ok;
    logic          timeout_hit;
    logic [3:0]    round_inc;

    assign start_ok    = StartGame && (numGames != 4'd0);
    assign grade_edge  = GradeIt && !grade_prev;
    assign shape_ok    = (LoadShape != 3'b000) && (LoadShape != 3'b111);
    assign timeout_hit = (timer == TW'(GRADE_TIMEOUT - 1));
    assign round_inc   = RoundNumber + 4'd1;

    // Next-state decision; a grader result takes priority over a timeout.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start_ok) state_next = LOAD;
            LOAD:       if (slot_mask == 4'b1111) state_next = GUESS;
            GUESS:      if (grade_edge) state_next = GRADE_WAIT;
            GRADE_WAIT: begin
                if (gradeDone) begin
                    if ((gradeZnarly == 4'd4) || (round_inc == 4'(MAX_ROUNDS)))
                        state_next = DONE;
                    else
                        state_next = GUESS;
                end else if (timeout_hit) begin
                    state_next = GUESS;
                end
            end
            default:    state_next = IDLE;
        endcase
    end

    // State register plus every registered output and bookkeeping register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            slot_mask     <= 4'b0000;
            grade_prev    <= 1'b0;
            timer         <= '0;
            useGame       <= 1'b0;
            masterPattern <= 12'h000;
            gradeStart    <= 1'b0;
            gradeGuess    <= 12'h000;
            Znarly        <= 4'd0;
            Zood          <= 4'd0;
            RoundNumber   <= 4'd0;
            loadingShape  <= 1'b0;
            ongoingGame   <= 1'b0;
            GameWon       <= 1'b0;
            gameOver      <= 1'b0;
            gradeError    <= 1'b0;
        end else begin
            state        <= state_next;
            grade_prev   <= GradeIt;
            useGame      <= 1'b0;
            gradeStart   <= 1'b0;
            loadingShape <= (state_next == LOAD);
            ongoingGame  <= (state_next == LOAD) || (state_next == GUESS) ||
                            (state_next == GRADE_WAIT);
            gameOver     <= (state_next == DONE);

            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        useGame       <= 1'b1;
                        masterPattern <= 12'h000;
                        slot_mask     <= 4'b0000;
                        RoundNumber   <= 4'd0;
                        Znarly        <= 4'd0;
                        Zood          <= 4'd0;
                        GameWon       <= 1'b0;
                        gradeError    <= 1'b0;
                        timer         <= '0;
                    end
                end
                LOAD: begin
                    if (LoadShapeNow && shape_ok) begin
                        case (ShapeLocation)
                            2'd0:    masterPattern[2:0]  <= LoadShape;
                            2'd1:    masterPattern[5:3]  <= LoadShape;
                            2'd2:    masterPattern[8:6]  <= LoadShape;
                            default: masterPattern[11:9] <= LoadShape;
                        endcase
                        slot_mask[ShapeLocation] <= 1'b1;
                    end
                end
                GUESS: begin
                    timer <= '0;
                    if (grade_edge) begin
                        gradeGuess <= Guess;
                        gradeStart <= 1'b1;
                    end
                end
                GRADE_WAIT: begin
                    if (gradeDone) begin
                        Znarly      <= gradeZnarly;
                        Zood        <= gradeZood;
                        RoundNumber <= round_inc;
                        GameWon     <= (gradeZnarly == 4'd4);
                        timer       <= '0;
                    end else if (timeout_hit) begin
                        gradeError <= 1'b1;
                        timer      <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_game_round_sequencer.sv
// Directed self-checking bench for game_round_sequencer.
module tb_game_round_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        StartGame = 1'b0;
    logic [3:0]  numGames = 4'd0;
    logic        useGame;
    logic [2:0]  LoadShape = 3'd0;
    logic [1:0]  ShapeLocation = 2'd0;
    logic        LoadShapeNow = 1'b0;
    logic [11:0] masterPattern;
    logic [11:0] Guess = 12'h000;
    logic        GradeIt = 1'b0;
    logic        gradeStart;
    logic [11:0] gradeGuess;
    logic        gradeDone = 1'b0;
    logic [3:0]  gradeZnarly = 4'd0;
    logic [3:0]  gradeZood = 4'd0;
    logic [3:0]  Znarly;
    logic [3:0]  Zood;
    logic [3:0]  RoundNumber;
    logic        loadingShape;
    logic        ongoingGame;
    logic        GameWon;
    logic        gameOver;
    logic        gradeError;

    int checks = 0;
    int errors = 0;
    int starts;

    game_round_sequencer #(.MAX_ROUNDS(8), .GRADE_TIMEOUT(15)) dut (
        .clock(clock), .reset_n(reset_n), .StartGame(StartGame), .numGames(numGames),
        .useGame(useGame), .LoadShape(LoadShape), .ShapeLocation(ShapeLocation),
        .LoadShapeNow(LoadShapeNow), .masterPattern(masterPattern), .Guess(Guess),
        .GradeIt(GradeIt), .gradeStart(gradeStart), .gradeGuess(gradeGuess),
        .gradeDone(gradeDone), .gradeZnarly(gradeZnarly), .gradeZood(gradeZood),
        .Znarly(Znarly), .Zood(Zood), .RoundNumber(RoundNumber),
        .loadingShape(loadingShape), .ongoingGame(ongoingGame), .GameWon(GameWon),
        .gameOver(gameOver), .gradeError(gradeError)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] all_outs();
        return {21'd0, useGame, masterPattern, gradeStart, gradeGuess, Znarly, Zood,
                RoundNumber, loadingShape, ongoingGame, GameWon, gameOver, gradeError};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_game();
        StartGame = 1'b1;
        tick();
        check("start_usegame", useGame, 1);
        check("start_loading", loadingShape, 1);
        StartGame = 1'b0;
        tick();
        check("usegame_one_cycle", useGame, 0);
    endtask

    task automatic load_all();
        LoadShapeNow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ShapeLocation = 2'(i);
            LoadShape = 3'(i + 1);
            tick();
        end
        LoadShapeNow = 1'b0;
        tick();
        check("load_all_guess", {loadingShape, ongoingGame}, 2'b01);
    endtask

    task automatic grade(input logic [3:0] zn, input logic [3:0] zo);
        GradeIt = 1'b1;
        tick();
        GradeIt = 1'b0;
        gradeDone = 1'b1;
        gradeZnarly = zn;
        gradeZood = zo;
        tick();
        gradeDone = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("reset_outputs", all_outs(), 0);
        reset_n = 1'b1;
        tick();

        // No credits: start request is refused
        numGames = 4'd0;
        StartGame = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("nocredit_usegame", useGame, 0);
            check("nocredit_idle", {loadingShape, ongoingGame}, 0);
        end
        StartGame = 1'b0;

        // Start with credits
        numGames = 4'd2;
        start_game();

        // Loading, including ignored code and slot rewrite
        LoadShapeNow = 1'b1;
        ShapeLocation = 2'd1; LoadShape = 3'b101; tick();
        check("slot1_101", masterPattern[5:3], 3'b101);
        ShapeLocation = 2'd2; LoadShape = 3'b011; tick();
        ShapeLocation = 2'd3; LoadShape = 3'b100; tick();
        ShapeLocation = 2'd0; LoadShape = 3'b111; tick();
        check("code111_ignored", masterPattern, 12'b100_011_101_000);
        LoadShapeNow = 1'b0;
        tick();
        check("mask_not_full", loadingShape, 1);
        LoadShapeNow = 1'b1;
        ShapeLocation = 2'd1; LoadShape = 3'b010; tick();
        ShapeLocation = 2'd0; LoadShape = 3'b001; tick();
        check("master_full", masterPattern, 12'b100011010001);
        LoadShapeNow = 1'b0;
        tick();
        check("enter_guess", {loadingShape, ongoingGame, gameOver}, 3'b010);

        // GradeIt held five cycles, grader answers on the fourth
        Guess = 12'h123;
        GradeIt = 1'b1;
        starts = 0;
        for (int i = 0; i < 5; i++) begin
            gradeDone = (i == 3);
            gradeZnarly = 4'd2;
            gradeZood = 4'd1;
            tick();
            if (gradeStart) starts++;
            if (i == 0) check("grade_guess_latch", gradeGuess, 12'h123);
        end
        gradeDone = 1'b0;
        GradeIt = 1'b0;
        check("single_gradestart", starts, 1);
        check("round1_result", {RoundNumber, Znarly, Zood}, 12'h121);
        check("back_in_guess", {ongoingGame, gameOver}, 2'b10);
        tick();

        // StartGame mid-game is ignored
        StartGame = 1'b1;
        tick();
        check("midgame_start", {useGame, loadingShape, RoundNumber}, 6'h01);
        StartGame = 1'b0;

        // Grader timeout
        Guess = 12'h456;
        GradeIt = 1'b1;
        tick();
        GradeIt = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("no_timeout_yet", gradeError, 0);
        tick();
        check("timeout_error", gradeError, 1);
        check("timeout_round", RoundNumber, 1);
        gradeDone = 1'b1; gradeZnarly = 4'd3; gradeZood = 4'd3;
        tick();
        gradeDone = 1'b0;
        check("late_done_ignored", {RoundNumber, Znarly, Zood}, 12'h121);

        // gradeDone coinciding with the timeout cycle wins
        GradeIt = 1'b1;
        tick();
        GradeIt = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        gradeDone = 1'b1; gradeZnarly = 4'd1; gradeZood = 4'd3;
        tick();
        gradeDone = 1'b0;
        check("done_beats_timeout", {RoundNumber, Znarly, Zood}, 12'h213);
        check("error_sticky", gradeError, 1);

        // Winning grade
        grade(4'd4, 4'd0);
        check("win_flags", {GameWon, gameOver, ongoingGame}, 3'b110);
        check("win_round", RoundNumber, 3);

        // New game from DONE, then lose after MAX_ROUNDS
        numGames = 4'd1;
        start_game();
        check("newgame_cleared", {masterPattern, RoundNumber, GameWon, gradeError}, 0);
        load_all();
        check("master_again", masterPattern, 12'b100011010001);
        for (int r = 0; r < 7; r++) grade(4'd1, 4'd2);
        check("round7_ongoing", {RoundNumber, gameOver}, {4'd7, 1'b0});
        grade(4'd1, 4'd2);
        check("lose_done", {RoundNumber, GameWon, gameOver, ongoingGame}, {4'd8, 3'b010});

        // Reset asserted during GRADE_WAIT
        start_game();
        load_all();
        GradeIt = 1'b1;
        tick();
        check("in_grade_wait", gradeStart, 1);
        GradeIt = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        check("midgame_reset", all_outs(), 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("idle_after_reset", {ongoingGame, gameOver, loadingShape}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
